// File: rtl/uart_bus_master_pkg.sv
// Shared constants and state encodings for the UART-driven debug bus master.
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h4B;
    localparam logic [7:0] NAK_BYTE = 8'h3F;

    // Cycles the reply sender waits for the UART to go busy before moving on anyway
    localparam logic [1:0] TX_LOW_WAIT_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_REQ    = 3'd3,
        ST_ACCESS = 3'd4,
        ST_RESP   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE     = 2'd0,
        TX_WAIT_RDY = 2'd1,
        TX_WAIT_LOW = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_bus_master_frame_tx.sv
// Reply sender: shifts out up to four payload bytes MSB first through the UART
// sender handshake and pulses o_done once the last byte has been handed over.
module uart_bus_master_frame_tx
    import uart_bus_master_pkg::*;
(
    input  logic        i_sysclk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_nbytes,
    input  logic [31:0] i_payload,
    input  logic        i_tx_status,
    output logic        o_tx_en,
    output logic [7:0]  o_tx_data,
    output logic        o_done
);

    tx_state_t   r_state;
    tx_state_t   w_next;
    logic [31:0] r_shift;
    logic [2:0]  r_left;
    logic [1:0]  r_wait;
    logic        r_txEn;
    logic [7:0]  r_txData;
    logic        w_send;
    logic        w_done;

    // Sequencer state register
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) r_state <= TX_IDLE;
        else         r_state <= w_next;
    end

    // Per byte: wait for an idle sender, fire it, then give the sender up to four cycles to go busy
    always_comb begin
        w_next = r_state;
        w_send = 1'b0;
        w_done = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (i_start) w_next = TX_WAIT_RDY;
            end
            TX_WAIT_RDY: begin
                if (i_tx_status) begin
                    w_send = 1'b1;
                    w_next = TX_WAIT_LOW;
                end
            end
            TX_WAIT_LOW: begin
                if (!i_tx_status || r_wait == TX_LOW_WAIT_LAST) begin
                    if (r_left == 3'd0) begin
                        w_done = 1'b1;
                        w_next = TX_IDLE;
                    end else begin
                        w_next = TX_WAIT_RDY;
                    end
                end
            end
            default: w_next = TX_IDLE;
        endcase
    end

    // Payload shifter, byte counter, busy-wait counter and the registered tx pulse/data
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_shift  <= 32'h0;
            r_left   <= 3'd0;
            r_wait   <= 2'd0;
            r_txEn   <= 1'b0;
            r_txData <= 8'h0;
        end else begin
            r_txEn <= w_send;
            if (r_state == TX_IDLE && i_start) begin
                r_shift <= i_payload;
                r_left  <= i_nbytes;
            end
            if (w_send) begin
                r_txData <= r_shift[31:24];
                r_shift  <= {r_shift[23:0], 8'h00};
                r_left   <= r_left - 3'd1;
            end
            if (r_state == TX_WAIT_LOW) r_wait <= r_wait + 2'd1;
            else                        r_wait <= 2'd0;
        end
    end

    assign o_tx_en   = r_txEn;
    assign o_tx_data = r_txData;
    assign o_done    = w_done;

endmodule

// File: rtl/uart_bus_master.sv
// UART debug initiator: decodes 'W'/'R' command frames, performs one word access
// on the shared data bus through the arbiter, and answers via the UART sender.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        i_sysclk,
    input  logic        i_reset,
    input  logic        i_rx_status,
    input  logic [7:0]  i_rx_data,
    input  logic        i_tx_status,
    output logic        o_tx_en,
    output logic [7:0]  o_tx_data,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    output logic        o_rd,
    output logic        o_wr,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rdata,
    output logic        o_busy
);

    state_t      r_state;
    state_t      w_next;
    logic        r_isWrite;
    logic [1:0]  r_byteCnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_idleCnt;
    logic        w_lastByte;
    logic        w_timeout;
    logic        w_start;
    logic [2:0]  w_nbytes;
    logic [31:0] w_payload;
    logic        w_txDone;

    assign w_lastByte = i_rx_status && (r_byteCnt == 2'd3);
    assign w_timeout  = (r_idleCnt == TIMEOUT_CYCLES - 32'd1);

    // Main frame/access state register
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Frame decode, bus handshake and reply launch; reads hand rdata to the sender in the access cycle
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_nbytes  = 3'd1;
        w_payload = {NAK_BYTE, 24'h0};
        case (r_state)
            ST_IDLE: begin
                if (i_rx_status) begin
                    if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) w_next = ST_ADDR;
                    else                                            w_next = ST_ERR;
                end
            end
            ST_ADDR: begin
                if (w_lastByte) begin
                    if (i_rx_data[1:0] != 2'b00) w_next = ST_ERR;
                    else if (r_isWrite)          w_next = ST_DATA;
                    else                         w_next = ST_REQ;
                end else if (!i_rx_status && w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_lastByte)                         w_next = ST_REQ;
                else if (!i_rx_status && w_timeout)     w_next = ST_IDLE;
            end
            ST_REQ: begin
                if (i_bus_gnt) w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_next  = ST_RESP;
                w_start = 1'b1;
                if (r_isWrite) begin
                    w_payload = {ACK_BYTE, 24'h0};
                end else begin
                    w_nbytes  = 3'd4;
                    w_payload = i_rdata;
                end
            end
            ST_ERR: begin
                w_next  = ST_RESP;
                w_start = 1'b1;
            end
            ST_RESP: begin
                if (w_txDone) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Command latch, address/data shift registers, byte counter and inter-byte idle counter
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_isWrite <= 1'b0;
            r_byteCnt <= 2'd0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_idleCnt <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_byteCnt <= 2'd0;
                    if (i_rx_status) r_isWrite <= (i_rx_data == CMD_WR);
                end
                ST_ADDR: begin
                    if (i_rx_status) begin
                        r_addr    <= {r_addr[23:0], i_rx_data};
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                ST_DATA: begin
                    if (i_rx_status) begin
                        r_wdata   <= {r_wdata[23:0], i_rx_data};
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                default: ;
            endcase
            if ((r_state == ST_ADDR || r_state == ST_DATA) && !i_rx_status)
                r_idleCnt <= r_idleCnt + 32'd1;
            else
                r_idleCnt <= 32'h0;
        end
    end

    uart_bus_master_frame_tx u_frameTx (
        .i_sysclk    (i_sysclk),
        .i_reset     (i_reset),
        .i_start     (w_start),
        .i_nbytes    (w_nbytes),
        .i_payload   (w_payload),
        .i_tx_status (i_tx_status),
        .o_tx_en     (o_tx_en),
        .o_tx_data   (o_tx_data),
        .o_done      (w_txDone)
    );

    assign o_bus_req = (r_state == ST_REQ) || (r_state == ST_ACCESS);
    assign o_rd      = (r_state == ST_ACCESS) && !r_isWrite;
    assign o_wr      = (r_state == ST_ACCESS) && r_isWrite;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed frames plus randomized
// read/write traffic checked against a word-memory reference model.
module tb_uart_bus_master;

    localparam logic [7:0] W_CMD = 8'h57;
    localparam logic [7:0] R_CMD = 8'h52;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxStatus = 1'b0;
    logic [7:0]  rxData = 8'h0;
    logic        txStatus = 1'b1;
    logic        txEn;
    logic [7:0]  txData;
    logic        busReq;
    logic        busGnt = 1'b1;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0]  replyQ[$];
    int          rdCount = 0;
    int          wrCount = 0;
    int          illegalCount = 0;
    int          txHold = 0;
    logic [31:0] lastWrAddr = 32'h0;
    logic [31:0] lastWrData = 32'h0;
    logic [31:0] lastRdAddr = 32'h0;
    logic [31:0] slaveMem [256] = '{default: 32'h0};
    logic [31:0] refMem [256] = '{default: 32'h0};
    logic        rdForce = 1'b1;
    logic [31:0] forcedVal = 32'h0;

    // Peripheral side of the bus: a 1 KB word memory (address bits 9:2) or a forced value
    assign rdata = rdForce ? forcedVal : slaveMem[addr[9:2]];

    uart_bus_master #(.TIMEOUT_CYCLES(32'd100)) dut (
        .i_sysclk    (clk),
        .i_reset     (rst),
        .i_rx_status (rxStatus),
        .i_rx_data   (rxData),
        .i_tx_status (txStatus),
        .o_tx_en     (txEn),
        .o_tx_data   (txData),
        .o_bus_req   (busReq),
        .i_bus_gnt   (busGnt),
        .o_rd        (rd),
        .o_wr        (wr),
        .o_addr      (addr),
        .o_wdata     (wdata),
        .i_rdata     (rdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // UART sender model plus bus monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (txEn) begin
            replyQ.push_back(txData);
            txHold = $urandom_range(1, 6);
            txStatus = 1'b0;
        end else if (txHold > 0) begin
            txHold = txHold - 1;
            if (txHold == 0) txStatus = 1'b1;
        end
        if (rd) begin
            rdCount = rdCount + 1;
            lastRdAddr = addr;
        end
        if (wr) begin
            wrCount = wrCount + 1;
            lastWrAddr = addr;
            lastWrData = wdata;
            slaveMem[addr[9:2]] = wdata;
        end
        if ((rd || wr) && !busReq) illegalCount = illegalCount + 1;
        if (rd && wr) illegalCount = illegalCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxData = b;
        rxStatus = 1'b1;
        tick(1);
        rxStatus = 1'b0;
        rxData = 8'h0;
        tick(2);
    endtask

    task automatic sendFrame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input bit withData);
        applyStimulus(cmd);
        for (int i = 3; i >= 0; i--) applyStimulus(a[8*i +: 8]);
        if (withData)
            for (int i = 3; i >= 0; i--) applyStimulus(d[8*i +: 8]);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(busy), 32'h0);
    endtask

    task automatic checkReply(input string tag, input logic [31:0] val, input int n);
        checkOutput({tag, "_len"}, 32'(replyQ.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] got;
            got = (i < replyQ.size()) ? replyQ[i] : 8'hxx;
            checkOutput($sformatf("%s_b%0d", tag, i), 32'(got), 32'(val[31 - 8*i -: 8]));
        end
        replyQ.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_txEn"}, 32'(txEn), 32'h0);
        checkOutput({tag, "_busReq"}, 32'(busReq), 32'h0);
        checkOutput({tag, "_rd"}, 32'(rd), 32'h0);
        checkOutput({tag, "_wr"}, 32'(wr), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_txData"}, 32'(txData), 32'h0);
        checkOutput({tag, "_addr"}, addr, 32'h0);
        checkOutput({tag, "_wdata"}, wdata, 32'h0);
    endtask

    task automatic pulseReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs(tag);
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Directed scenarios followed by randomized traffic against the reference memory
    initial begin
        int rd0;
        int wr0;
        int n;
        int lowCycles;
        #2;
        checkResetOutputs("reset");
        tick(2);
        rst = 1'b0;
        tick(2);

        // Write frame with grant tied high
        wr0 = wrCount;
        sendFrame(W_CMD, 32'h0000000C, 32'h000000A5, 1'b1);
        waitIdle("wr_idle");
        checkOutput("wr_count", 32'(wrCount - wr0), 32'd1);
        checkOutput("wr_addr", lastWrAddr, 32'h0000000C);
        checkOutput("wr_data", lastWrData, 32'h000000A5);
        checkReply("wr_reply", 32'h4B000000, 1);
        refMem[3] = 32'h000000A5;

        // Read frame with forced peripheral data
        forcedVal = 32'h0000005A;
        rd0 = rdCount;
        sendFrame(R_CMD, 32'h40000010, 32'h0, 1'b0);
        waitIdle("rd_idle");
        checkOutput("rd_count", 32'(rdCount - rd0), 32'd1);
        checkOutput("rd_addr", lastRdAddr, 32'h40000010);
        checkReply("rd_reply", 32'h0000005A, 4);

        // Grant withheld for 50 cycles
        busGnt = 1'b0;
        forcedVal = 32'h12345678;
        rd0 = rdCount;
        wr0 = wrCount;
        sendFrame(R_CMD, 32'h00000100, 32'h0, 1'b0);
        lowCycles = 0;
        for (int i = 0; i < 50; i++) begin
            if (!busReq) lowCycles++;
            tick(1);
        end
        checkOutput("hold_req_low_cycles", 32'(lowCycles), 32'd0);
        checkOutput("hold_no_access", 32'((rdCount - rd0) + (wrCount - wr0)), 32'd0);
        busGnt = 1'b1;
        tick(1);
        checkOutput("hold_rd_after_gnt", 32'(rd), 32'd1);
        waitIdle("hold_idle");
        checkOutput("hold_rd_count", 32'(rdCount - rd0), 32'd1);
        checkReply("hold_reply", 32'h12345678, 4);

        // Bad command byte and misaligned read
        rd0 = rdCount;
        applyStimulus(8'h11);
        waitIdle("badcmd_idle");
        checkReply("badcmd_reply", 32'h3F000000, 1);
        sendFrame(R_CMD, 32'h00000002, 32'h0, 1'b0);
        waitIdle("misal_idle");
        checkReply("misal_reply", 32'h3F000000, 1);
        checkOutput("misal_no_rd", 32'(rdCount - rd0), 32'd0);

        // Partial frame then silence beyond the timeout
        wr0 = wrCount;
        applyStimulus(W_CMD);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        tick(150);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        checkOutput("timeout_no_reply", 32'(replyQ.size()), 32'd0);
        checkOutput("timeout_no_wr", 32'(wrCount - wr0), 32'd0);
        forcedVal = 32'hCAFEF00D;
        sendFrame(R_CMD, 32'h00000020, 32'h0, 1'b0);
        waitIdle("after_to_idle");
        checkReply("after_to_reply", 32'hCAFEF00D, 4);

        // Reset while receiving data bytes
        wr0 = wrCount;
        applyStimulus(W_CMD);
        for (int i = 0; i < 4; i++) applyStimulus(8'h00);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        pulseReset("rst_data");
        checkOutput("rst_data_no_wr", 32'(wrCount - wr0), 32'd0);
        replyQ.delete();
        sendFrame(W_CMD, 32'h00000030, 32'h0BADBEEF, 1'b1);
        waitIdle("post_rst1_idle");
        checkOutput("post_rst1_wr", lastWrData, 32'h0BADBEEF);
        checkReply("post_rst1_reply", 32'h4B000000, 1);
        refMem[12] = 32'h0BADBEEF;

        // Reset while the read reply is being sent
        forcedVal = 32'hA1B2C3D4;
        sendFrame(R_CMD, 32'h00000040, 32'h0, 1'b0);
        n = 0;
        while (replyQ.size() == 0 && n < 500) begin
            tick(1);
            n++;
        end
        checkOutput("rst_resp_started", 32'(replyQ.size() > 0), 32'd1);
        pulseReset("rst_resp");
        replyQ.delete();
        forcedVal = 32'h5566AA77;
        sendFrame(R_CMD, 32'h00000044, 32'h0, 1'b0);
        waitIdle("post_rst2_idle");
        checkReply("post_rst2_reply", 32'h5566AA77, 4);

        // Randomized traffic against the reference memory
        rdForce = 1'b0;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            bit isWr;
            bit mis;
            isWr = ($urandom_range(0, 1) == 1);
            mis  = ($urandom_range(0, 4) == 0);
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 7));
            a[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
            d = $urandom;
            rd0 = rdCount;
            wr0 = wrCount;
            busGnt = 1'b0;
            sendFrame(isWr ? W_CMD : R_CMD, a, d, isWr && !mis);
            tick($urandom_range(0, 5));
            busGnt = 1'b1;
            waitIdle($sformatf("rand%0d_idle", i));
            if (mis) begin
                checkReply($sformatf("rand%0d_nak", i), 32'h3F000000, 1);
                checkOutput($sformatf("rand%0d_noacc", i), 32'((rdCount - rd0) + (wrCount - wr0)), 32'd0);
            end else if (isWr) begin
                refMem[a[9:2]] = d;
                checkReply($sformatf("rand%0d_ack", i), 32'h4B000000, 1);
                checkOutput($sformatf("rand%0d_wrcnt", i), 32'(wrCount - wr0), 32'd1);
                checkOutput($sformatf("rand%0d_wraddr", i), lastWrAddr, a);
                checkOutput($sformatf("rand%0d_wrdata", i), lastWrData, d);
            end else begin
                checkReply($sformatf("rand%0d_rdval", i), refMem[a[9:2]], 4);
                checkOutput($sformatf("rand%0d_rdcnt", i), 32'(rdCount - rd0), 32'd1);
                checkOutput($sformatf("rand%0d_rdaddr", i), lastRdAddr, a);
            end
        end

        checkOutput("no_illegal_strobes", 32'(illegalCount), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
